// File: rtl/tile_wb_arb_pkg.sv
// Shared types and widths for the tile Wishbone arbiter.
package tile_wb_arb_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CTI_W = 3;
  localparam int unsigned BTE_W = 2;
  localparam int unsigned TMO_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // Request payload forwarded from the owning master to the slave port
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic [CTI_W-1:0] cti;
    logic [BTE_W-1:0] bte;
    logic             we;
  } wb_req_t;

endpackage

// File: rtl/tile_wb_arb_if.sv
// Bundle of the flattened master ports and the shared slave port.
interface tile_wb_arb_if
  import tile_wb_arb_pkg::*;
#(
  parameter int unsigned NR_MASTERS = 2
);

  logic [ADR_W*NR_MASTERS-1:0] m_adr_i;
  logic [DAT_W*NR_MASTERS-1:0] m_dat_i;
  logic [SEL_W*NR_MASTERS-1:0] m_sel_i;
  logic [CTI_W*NR_MASTERS-1:0] m_cti_i;
  logic [BTE_W*NR_MASTERS-1:0] m_bte_i;
  logic [NR_MASTERS-1:0]       m_cyc_i;
  logic [NR_MASTERS-1:0]       m_stb_i;
  logic [NR_MASTERS-1:0]       m_we_i;
  logic [NR_MASTERS-1:0]       m_ack_o;
  logic [NR_MASTERS-1:0]       m_err_o;
  logic [NR_MASTERS-1:0]       m_rty_o;
  logic [DAT_W*NR_MASTERS-1:0] m_dat_o;

  logic [ADR_W-1:0]            s_adr_o;
  logic [DAT_W-1:0]            s_dat_o;
  logic [SEL_W-1:0]            s_sel_o;
  logic [CTI_W-1:0]            s_cti_o;
  logic [BTE_W-1:0]            s_bte_o;
  logic                        s_cyc_o;
  logic                        s_stb_o;
  logic                        s_we_o;
  logic                        s_ack_i;
  logic                        s_err_i;
  logic                        s_rty_i;
  logic [DAT_W-1:0]            s_dat_i;

  logic [NR_MASTERS-1:0]       grant_o;

  // Arbiter side
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i, m_we_i,
    input  s_ack_i, s_err_i, s_rty_i, s_dat_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o,
    output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o, s_we_o,
    output grant_o
  );

  // Environment side (masters plus the shared slave)
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i, m_we_i,
    output s_ack_i, s_err_i, s_rty_i, s_dat_i,
    input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o, s_we_o,
    input  grant_o
  );

endinterface

// File: rtl/tile_wb_arbiter_rr_select.sv
// Round-robin winner pick: first requester after last_owner, wrapping.
module rr_select
  import tile_wb_arb_pkg::*;
#(
  parameter int unsigned NR_MASTERS = 2,
  parameter int unsigned IDX_W      = 1
) (
  input  logic [NR_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]      last_owner,
  output logic [NR_MASTERS-1:0] winner
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan from last_owner+1 around the ring; the first hit wins
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NR_MASTERS; i++) begin
      idx = IDX_W'((32'(last_owner) + i) % NR_MASTERS);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one tile slave port among masters.
// Optional stall watchdog enabled by defining TILE_WB_ARB_TIMEOUT_EN.
module tile_wb_arbiter
  import tile_wb_arb_pkg::*;
#(
  parameter int unsigned NR_MASTERS = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic          clk,
  input logic          rst_n,
  tile_wb_arb_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NR_MASTERS);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d, last_q, last_d, win_idx_c;
  logic [NR_MASTERS-1:0] grant_q, grant_d, win_c, ack_c, err_c, rty_c;
  wb_req_t               req_a [NR_MASTERS];
  wb_req_t               own_req_c;
  logic                  owned_c, own_cyc_c, own_stb_c, tmo_hit_c;

  rr_select #(
    .NR_MASTERS (NR_MASTERS),
    .IDX_W      (IDX_W)
  ) u_rr_select (
    .req        (bus.m_cyc_i),
    .last_owner (last_q),
    .winner     (win_c)
  );

  // Unflatten each master's payload
  for (genvar k = 0; k < NR_MASTERS; k++) begin : g_slice
    assign req_a[k] = {bus.m_adr_i[ADR_W*k +: ADR_W], bus.m_dat_i[DAT_W*k +: DAT_W],
                       bus.m_sel_i[SEL_W*k +: SEL_W], bus.m_cti_i[CTI_W*k +: CTI_W],
                       bus.m_bte_i[BTE_W*k +: BTE_W], bus.m_we_i[k]};
  end

  assign own_req_c = req_a[owner_q];
  assign owned_c   = (state_q == OWNED);
  assign own_cyc_c = owned_c & bus.m_cyc_i[owner_q];
  assign own_stb_c = owned_c & bus.m_stb_i[owner_q];

  // One-hot winner to index
  always_comb begin
    win_idx_c = '0;
    for (int unsigned i = 0; i < NR_MASTERS; i++) begin
      if (win_c[IDX_W'(i)]) win_idx_c = IDX_W'(i);
    end
  end

  // Next-state and termination routing
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_c   = '0;
    err_c   = '0;
    rty_c   = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          state_d = OWNED;
          owner_d = win_idx_c;
          grant_d = win_c;
        end
      end
      OWNED: begin
        ack_c[owner_q] = bus.s_ack_i;
        err_c[owner_q] = bus.s_err_i | tmo_hit_c;
        rty_c[owner_q] = bus.s_rty_i;
        if (!bus.m_cyc_i[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          grant_d = '0;
        end
      end
    endcase
  end

  // State and ownership registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NR_MASTERS - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

`ifdef TILE_WB_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic             term_c, stall_c;

  assign term_c    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign stall_c   = own_cyc_c & own_stb_c & ~term_c;
  assign tmo_hit_c = stall_c && (tmo_q == TMO_W'(TIMEOUT - 1));

  // Count unanswered strobe cycles of the current owner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (!owned_c || state_d != OWNED || term_c || tmo_hit_c) begin
      tmo_q <= '0;
    end else if (stall_c) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_timeout;

  // Without the watchdog TIMEOUT has no effect
  assign tmo_hit_c      = 1'b0;
  assign unused_timeout = ^TMO_W'(TIMEOUT);
`endif

  // Slave port follows the owner; a watchdog hit drops the cycle
  assign bus.s_cyc_o = own_cyc_c & ~tmo_hit_c;
  assign bus.s_stb_o = own_stb_c & ~tmo_hit_c;
  assign bus.s_we_o  = owned_c & own_req_c.we;
  assign bus.s_adr_o = own_req_c.adr;
  assign bus.s_dat_o = own_req_c.dat;
  assign bus.s_sel_o = own_req_c.sel;
  assign bus.s_cti_o = own_req_c.cti;
  assign bus.s_bte_o = own_req_c.bte;

  assign bus.m_ack_o = ack_c;
  assign bus.m_err_o = err_c;
  assign bus.m_rty_o = rty_c;
  assign bus.m_dat_o = {NR_MASTERS{bus.s_dat_i}};
  assign bus.grant_o = grant_q;

endmodule

// File: tb/tb_tile_wb_arbiter.sv
// Self-checking bench for tile_wb_arbiter: directed scenarios plus random traffic
// against a behavioural ownership model. Honours TILE_WB_ARB_TIMEOUT_EN.
module tb_tile_wb_arbiter;

  localparam int NR  = 2;
  localparam int TMO = 8;
`ifdef TILE_WB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_wb_arb_if #(.NR_MASTERS(NR)) bus ();

  tile_wb_arbiter #(
    .NR_MASTERS (NR),
    .TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: current owner (-1 = idle), last owner, stalled-cycle count
  int mo = -1;
  int ml = NR - 1;
  int mcnt = 0;

  logic [31:0]   p_adr [NR];
  logic [31:0]   p_dat [NR];
  logic [3:0]    p_sel [NR];
  logic [2:0]    p_cti [NR];
  logic [1:0]    p_bte [NR];
  logic [NR-1:0] p_we;

  logic [NR-1:0] o_grant, o_ack, o_err;
  logic          o_scyc, o_sstb;
  logic [2:0]    o_cti;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NR; k++) begin
      p_adr[k] = $urandom;
      p_dat[k] = $urandom;
      p_sel[k] = 4'($urandom);
      p_cti[k] = 3'($urandom);
      p_bte[k] = 2'($urandom);
      p_we[k]  = 1'($urandom);
    end
  endtask

  // One bus cycle: drive, check against the model, advance the model
  task automatic step(input bit rv, input logic [NR-1:0] cv, input logic [NR-1:0] sv,
                      input bit ak, input bit er, input bit ry);
    logic [31:0]   sdat;
    logic [NR-1:0] e_grant, e_ack, e_err, e_rty;
    bit            stall, hit, e_cyc, e_stb;
    int            c;
    @(negedge clk);
    sdat          = $urandom;
    rst_n         = rv;
    bus.m_cyc_i   = cv;
    bus.m_stb_i   = sv;
    bus.m_we_i    = p_we;
    bus.s_ack_i   = ak;
    bus.s_err_i   = er;
    bus.s_rty_i   = ry;
    bus.s_dat_i   = sdat;
    for (int k = 0; k < NR; k++) begin
      bus.m_adr_i[32*k +: 32] = p_adr[k];
      bus.m_dat_i[32*k +: 32] = p_dat[k];
      bus.m_sel_i[4*k +: 4]   = p_sel[k];
      bus.m_cti_i[3*k +: 3]   = p_cti[k];
      bus.m_bte_i[2*k +: 2]   = p_bte[k];
    end
    #1;
    stall   = (mo >= 0) && cv[mo] && sv[mo] && !(ak || er || ry);
    hit     = TMO_EN && stall && (mcnt == TMO - 1);
    e_grant = '0;
    e_ack   = '0;
    e_err   = '0;
    e_rty   = '0;
    if (mo >= 0) begin
      e_grant[mo] = 1'b1;
      e_ack[mo]   = ak;
      e_err[mo]   = er || hit;
      e_rty[mo]   = ry;
    end
    e_cyc = (mo >= 0) && cv[mo] && !hit;
    e_stb = (mo >= 0) && sv[mo] && !hit;
    chk("grant", bus.grant_o, e_grant);
    chk("s_cyc", bus.s_cyc_o, e_cyc);
    chk("s_stb", bus.s_stb_o, e_stb);
    chk("m_ack", bus.m_ack_o, e_ack);
    chk("m_err", bus.m_err_o, e_err);
    chk("m_rty", bus.m_rty_o, e_rty);
    chk("m_dat", bus.m_dat_o, {NR{sdat}});
    if (mo >= 0) begin
      chk("s_adr", bus.s_adr_o, p_adr[mo]);
      chk("s_dat", bus.s_dat_o, p_dat[mo]);
      chk("s_sel_cti_bte_we", {bus.s_sel_o, bus.s_cti_o, bus.s_bte_o, bus.s_we_o},
          {p_sel[mo], p_cti[mo], p_bte[mo], p_we[mo]});
    end
    o_grant = bus.grant_o;
    o_scyc  = bus.s_cyc_o;
    o_sstb  = bus.s_stb_o;
    o_ack   = bus.m_ack_o;
    o_err   = bus.m_err_o;
    o_cti   = bus.s_cti_o;
    if (!rv) begin
      mo = -1; ml = NR - 1; mcnt = 0;
    end else if (mo < 0) begin
      mcnt = 0;
      for (int i = 1; i <= NR; i++) begin
        c = (ml + i) % NR;
        if (cv[c]) begin
          mo = c;
          break;
        end
      end
    end else if (!cv[mo]) begin
      ml = mo; mo = -1; mcnt = 0;
    end else if (hit || ak || er || ry) begin
      mcnt = 0;
    end else if (stall) begin
      mcnt++;
    end
  endtask

  initial begin
    int            held [NR];
    int            hold [NR];
    logic [NR-1:0] gseq [$];
    int            owners [$];
    int            gaps [$];
    int            run, cur, errs, first_err;
    bit            stb_at_err;
    logic [NR-1:0] cv, sv;

    rand_payload();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;

    // Reset state, even with requests pending
    step(0, '0, '0, 0, 0, 0);
    step(0, '1, '1, 1, 0, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_scyc", o_scyc, 0);

    // Single master, slave acks on cycle 3
    step(1, 2'b01, 2'b01, 0, 0, 0);
    chk("single_c0_scyc", o_scyc, 0);
    step(1, 2'b01, 2'b01, 0, 0, 0);
    chk("single_c1_scyc", o_scyc, 1);
    chk("single_c1_grant", o_grant, 2'b01);
    step(1, 2'b01, 2'b01, 0, 0, 0);
    step(1, 2'b01, 2'b01, 1, 0, 0);
    chk("single_c3_ack", o_ack, 2'b01);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);

    // Contention: both request, each owner holds cyc for 4 cycles
    step(0, '0, '0, 0, 0, 0);
    for (int k = 0; k < NR; k++) held[k] = 0;
    for (int n = 0; n < 26; n++) begin
      cur = mo;
      cv  = '1;
      if (cur >= 0 && held[cur] >= 4) cv[cur] = 1'b0;
      step(1, cv, cv, 1, 0, 0);
      gseq.push_back(o_grant);
      if (cur >= 0) held[cur] = cv[cur] ? held[cur] + 1 : 0;
    end
    run = -1;
    foreach (gseq[i]) begin
      if (gseq[i] == '0) begin
        if (run >= 0) run++;
      end else if (i == 0 || gseq[i-1] == '0) begin
        owners.push_back(gseq[i] == 2'b10 ? 1 : 0);
        if (run >= 0) gaps.push_back(run);
        run = 0;
      end
    end
    chk("cont_nr_owners", owners.size() >= 4, 1);
    for (int i = 0; i < 4 && i < owners.size(); i++)
      chk($sformatf("cont_owner%0d", i), owners[i], i % 2);
    for (int i = 0; i < 3 && i < gaps.size(); i++)
      chk($sformatf("cont_gap%0d", i), gaps[i], 1);

    // Burst by master 1 while master 0 waits
    step(1, '0, '0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0);
    p_cti[1] = 3'b010;
    step(1, 2'b10, 2'b10, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      p_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      step(1, 2'b11, 2'b10, 1, 0, 0);
      chk($sformatf("burst_grant_b%0d", b), o_grant, 2'b10);
      chk($sformatf("burst_cti_b%0d", b), o_cti, (b == 3) ? 3'b111 : 3'b010);
    end
    step(1, 2'b01, 2'b01, 0, 0, 0);
    chk("burst_drop_grant", o_grant, 2'b10);
    step(1, 2'b01, 2'b01, 0, 0, 0);
    chk("burst_idle_grant", o_grant, 2'b00);
    step(1, 2'b01, 2'b01, 1, 0, 0);
    chk("burst_next_grant", o_grant, 2'b01);

    // Silent slave: watchdog fires on the TMO-th stalled cycle when enabled
    step(0, '0, '0, 0, 0, 0);
    errs = 0;
    first_err = -1;
    stb_at_err = 1'b0;
    for (int n = 0; n < 14; n++) begin
      step(1, 2'b01, 2'b01, 0, 0, 0);
      if (o_err != '0) begin
        errs++;
        if (first_err < 0) begin
          first_err  = n;
          stb_at_err = o_sstb;
        end
      end
      if (n == TMO) chk("tmo_stb_at_limit", o_sstb, TMO_EN ? 0 : 1);
    end
    chk("tmo_err_count", errs, TMO_EN ? 1 : 0);
    chk("tmo_err_cycle", first_err, TMO_EN ? TMO : -1);
    chk("tmo_err_stb", stb_at_err, 0);
    step(1, '0, '0, 0, 0, 0);

    // Reset in the middle of a burst
    step(0, '0, '0, 0, 0, 0);
    step(1, 2'b11, 2'b11, 1, 0, 0);
    step(1, 2'b11, 2'b11, 1, 0, 0);
    chk("rstmid_owned", o_grant, 2'b01);
    step(1, 2'b11, 2'b11, 1, 0, 0);
    step(0, 2'b11, 2'b11, 1, 0, 0);
    step(1, 2'b11, 2'b11, 1, 0, 0);
    chk("rstmid_grant", o_grant, 2'b00);
    chk("rstmid_scyc", o_scyc, 0);
    chk("rstmid_ack", o_ack, 2'b00);
    step(1, 2'b11, 2'b11, 1, 0, 0);
    chk("rstmid_first_tie", o_grant, 2'b01);
    step(1, '0, '0, 0, 0, 0);

    // Random traffic
    for (int k = 0; k < NR; k++) hold[k] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (hold[k] > 0) begin
          hold[k]--;
          cv[k] = 1'b1;
        end else if ($urandom_range(0, 3) == 0) begin
          hold[k] = $urandom_range(1, 8);
          cv[k]   = 1'b1;
        end else begin
          cv[k] = 1'b0;
        end
        sv[k] = cv[k] & 1'($urandom);
      end
      rand_payload();
      step($urandom_range(0, 99) != 0, cv, sv, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_wb_arbiter.md
TILE_WB_ARBITER -- requirements
Module: tile_wb_arbiter

Interface
REQ-001 Parameter NR_MASTERS, default 2, number of Wishbone masters sharing the tile bus port (range 2..8).
REQ-002 Parameter TIMEOUT, default 255, stalled-cycle limit in clk cycles (range 1..65535).
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 m_adr_i  in  32*NR_MASTERS  flattened master addresses; master k occupies [32k+31:32k].
REQ-006 m_dat_i  in  32*NR_MASTERS  flattened master write data.
REQ-007 m_sel_i  in  4*NR_MASTERS  byte selects.
REQ-008 m_cti_i  in  3*NR_MASTERS  cycle type.
REQ-009 m_bte_i  in  2*NR_MASTERS  burst type.
REQ-010 m_cyc_i, m_stb_i, m_we_i  in  NR_MASTERS  per-master cycle, strobe and write enable.
REQ-011 m_ack_o, m_err_o, m_rty_o  out  NR_MASTERS  per-master terminations.
REQ-012 m_dat_o  out  32*NR_MASTERS  read data; every slice carries s_dat_i.
REQ-013 s_adr_o/s_dat_o (32), s_sel_o (4), s_cti_o (3), s_bte_o (2), s_cyc_o/s_stb_o/s_we_o (1)  out  shared slave port.
REQ-014 s_ack_i/s_err_i/s_rty_i (1), s_dat_i (32)  in  slave responses.
REQ-015 grant_o  out  NR_MASTERS  one-hot current owner; all zero when idle.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and OWNED.
REQ-017 In IDLE with at least one m_cyc_i high, the block SHALL select round-robin, starting at (last_owner+1) mod NR_MASTERS, and register the winner; it SHALL enter OWNED on the next edge.
REQ-018 Grant latency: s_cyc_o SHALL rise exactly 1 cycle after the winner's m_cyc_i is first sampled in IDLE.
REQ-019 In OWNED, the s_* outputs SHALL be driven combinationally from the owner's m_* inputs.
REQ-020 In OWNED, s_ack_i/s_err_i/s_rty_i SHALL be routed to the owner only; non-owners SHALL see 0.
REQ-021 In IDLE, s_cyc_o, s_stb_o and all m_ack_o/m_err_o/m_rty_o SHALL be 0.
REQ-022 Ownership SHALL be held while the owner's m_cyc_i stays high, across bursts and multiple strobes, with no preemption.
REQ-023 When the owner's m_cyc_i is sampled low in OWNED, the block SHALL return to IDLE and set last_owner to the owner; re-arbitration then follows the IDLE rule, so the bus is idle for at least 1 cycle between owners.
REQ-024 With simultaneous requests, masters SHALL be served in rotating order; a master SHALL never wait more than NR_MASTERS-1 ownership periods.
REQ-025 A master that drops m_cyc_i before it is granted SHALL simply be skipped; no state is kept for it.

Reset
REQ-026 With rst_n low at a clock edge: state becomes IDLE, grant_o is 0, last_owner is NR_MASTERS-1 (master 0 wins first), and the timeout counter is 0.
REQ-027 Reset asserted mid-cycle SHALL drop s_cyc_o on the next edge; no termination SHALL be issued to the aborted master.

Configuration
REQ-028 Macro TILE_WB_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL increment each OWNED cycle in which s_stb_o=1 and no slave termination arrives, and clear on any termination or state change.
REQ-029 When the counter reaches TIMEOUT, the block SHALL, in that same cycle, assert m_err_o to the owner for 1 cycle, force s_cyc_o/s_stb_o to 0, and clear the counter.
REQ-030 Macro undefined: no counter logic SHALL be present, and m_err_o SHALL be sourced only from s_err_i.

Structure
REQ-031 Package tile_wb_arb_pkg SHALL hold the arb_state_t enum (IDLE, OWNED), the timeout counter width constant (16), and the flattened-slice width constants (32/4/3/2).
REQ-032 Winner selection SHALL live in one combinational sub-module, rr_select (inputs: request vector, last_owner; output: one-hot winner); all registers stay in tile_wb_arbiter.

Verification
REQ-033 Single master: m_cyc_i[0]=1 at cycle 0, slave acks at cycle 3 → s_cyc_o=1 at cycle 1, m_ack_o[0]=1 at cycle 3, grant_o=2'b01.
REQ-034 Contention: both masters request continuously, each holding cyc for 4 cycles → grants 0,1,0,1 with exactly 1 idle cycle between owners.
REQ-035 Burst: master 1 sends a 4-beat incrementing burst (cti=3'b010, then 3'b111) while master 0 requests → master 0 is not granted until master 1 drops cyc.
REQ-036 Timeout (macro on, TIMEOUT=8): slave never acks → m_err_o[owner]=1 on the 8th stalled cycle, s_stb_o=0 that cycle; macro off → cycle stalls indefinitely.
REQ-037 Reset mid-burst: rst_n=0 during OWNED → next edge gives grant_o=0 and s_cyc_o=0; after release, master 0 wins the first tie.
